// File: rtl/operand_loader.sv
// Double-buffered operand feeder: nibbles fill a shadow set, which is moved to the
// active set a..e and held stable for HOLD_CYCLES while the next frame fills.
module operand_loader #(
  parameter int WIDTH       = 4,
  parameter int NUM_OPS     = 5,
  parameter int HOLD_CYCLES = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic             issue,
  output logic             busy,
  output logic [7:0]       frame_count
);

  localparam int IW = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic {
    ST_IDLE,
    ST_HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shadow_q [NUM_OPS];
  logic [WIDTH-1:0] shadow_d [NUM_OPS];
  logic [WIDTH-1:0] active_q [NUM_OPS];
  logic [WIDTH-1:0] active_d [NUM_OPS];
  logic [IW-1:0]    fill_idx_q, fill_idx_d;
  logic             shadow_full_q, shadow_full_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             issue_q, issue_d;
  logic [7:0]       frame_count_q, frame_count_d;

  logic accept;
  logic transfer;

  // in_ready depends on registered state only
  assign in_ready = !shadow_full_q;
  assign accept   = in_valid && in_ready && !flush;
  assign transfer = shadow_full_q && ((state_q == ST_IDLE) || (hold_q == '0));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      shadow_q      <= '{default: '0};
      active_q      <= '{default: '0};
      fill_idx_q    <= '0;
      shadow_full_q <= 1'b0;
      hold_q        <= '0;
      issue_q       <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      fill_idx_q    <= fill_idx_d;
      shadow_full_q <= shadow_full_d;
      hold_q        <= hold_d;
      issue_q       <= issue_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Shadow fill side
  always_comb begin
    shadow_d      = shadow_q;
    fill_idx_d    = fill_idx_q;
    shadow_full_d = shadow_full_q;
    if (accept) begin
      shadow_d[fill_idx_q] = in_data;
      if (fill_idx_q == IW'(NUM_OPS - 1)) begin
        fill_idx_d    = '0;
        shadow_full_d = 1'b1;
      end else begin
        fill_idx_d = fill_idx_q + 1'b1;
      end
    end
    if (transfer) begin
      shadow_full_d = 1'b0;
    end
    // flush after transfer: a coinciding transfer still captures the full shadow
    if (flush) begin
      fill_idx_d    = '0;
      shadow_full_d = 1'b0;
    end
  end

  // Hold FSM next state
  always_comb begin
    state_d       = state_q;
    active_d      = active_q;
    hold_d        = hold_q;
    issue_d       = 1'b0;
    frame_count_d = frame_count_q;
    if (transfer) begin
      state_d       = ST_HOLD;
      active_d      = shadow_q;
      hold_d        = HW'(HOLD_CYCLES - 1);
      issue_d       = 1'b1;
      frame_count_d = frame_count_q + 8'd1;
    end else if (state_q == ST_HOLD) begin
      if (hold_q == '0) begin
        state_d = ST_IDLE;
      end else begin
        hold_d = hold_q - 1'b1;
      end
    end
  end

  // Outputs
  always_comb begin
    busy        = (state_q == ST_HOLD);
    issue       = issue_q;
    frame_count = frame_count_q;
    a           = active_q[0];
    b           = active_q[1];
    c           = active_q[2];
    d           = active_q[3];
    e           = active_q[4];
  end

endmodule

// File: tb/tb_operand_loader.sv
// Randomized bench for operand_loader: a timestamp-based frame model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_operand_loader;

  localparam int WIDTH = 4;
  localparam int NOPS  = 5;
  localparam int HOLD  = 5;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic [WIDTH-1:0] a, b, c, d, e;
  logic             issue;
  logic             busy;
  logic [7:0]       frame_count;

  operand_loader #(.WIDTH(WIDTH), .NUM_OPS(NOPS), .HOLD_CYCLES(HOLD)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .a(a), .b(b), .c(c), .d(d), .e(e),
    .issue(issue), .busy(busy), .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: frames as queues, hold window from edge timestamps
  int m_edge, m_last, m_xfers;
  bit m_have, m_waiting;
  int m_partial[$];
  int m_wait_frame[NOPS];
  int m_act[NOPS];

  task automatic model_clear();
    m_edge = 0; m_last = 0; m_xfers = 0; m_have = 0; m_waiting = 0;
    m_partial.delete();
    for (int i = 0; i < NOPS; i++) begin
      m_wait_frame[i] = 0;
      m_act[i] = 0;
    end
  endtask

  initial model_clear();

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      model_clear();
    end else begin
      bit acc, xfer;
      m_edge++;
      acc  = in_valid && !m_waiting && !flush;
      xfer = m_waiting && (!m_have || (m_edge - m_last >= HOLD));
      if (xfer) begin
        m_act     = m_wait_frame;
        m_last    = m_edge;
        m_have    = 1;
        m_xfers++;
        m_waiting = 0;
      end
      if (flush) begin
        m_partial.delete();
        m_waiting = 0;
      end else if (acc) begin
        m_partial.push_back(int'(in_data));
        if (m_partial.size() == NOPS) begin
          for (int i = 0; i < NOPS; i++) m_wait_frame[i] = m_partial[i];
          m_partial.delete();
          m_waiting = 1;
        end
      end
    end
  end

  int cyc_n = 0;
  int issue_cyc[$];

  always @(negedge clock) begin
    logic [WIDTH-1:0] ops[NOPS];
    cyc_n++;
    if (issue === 1'b1) issue_cyc.push_back(cyc_n);
    ops = '{a, b, c, d, e};
    chk("in_ready", in_ready, !m_waiting);
    chk("busy", busy, m_have && (m_edge - m_last < HOLD));
    chk("issue", issue, m_have && (m_last == m_edge));
    chk("frame_count", frame_count, m_xfers % 256);
    for (int i = 0; i < NOPS; i++) chk("operand", ops[i], m_act[i]);
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic send_nib(input int v);
    int n = 0;
    in_valid = 1'b1;
    in_data  = WIDTH'(v);
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("send_ready_timeout", n < 50, 1);
    tick();
  endtask

  task automatic send_frame(input int v0, input int v1, input int v2, input int v3, input int v4);
    send_nib(v0); send_nib(v1); send_nib(v2); send_nib(v3); send_nib(v4);
    in_valid = 1'b0;
  endtask

  task automatic wait_issue();
    int n = 0;
    while (issue !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("issue_timeout", n < 50, 1);
  endtask

  task automatic chk_set(input string name, input int v0, input int v1, input int v2,
                         input int v3, input int v4);
    chk({name, "_a"}, a, v0); chk({name, "_b"}, b, v1); chk({name, "_c"}, c, v2);
    chk({name, "_d"}, d, v3); chk({name, "_e"}, e, v4);
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) tick();
    chk_set("reset", 0, 0, 0, 0, 0);
    chk("reset_ready", in_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_count", frame_count, 0);
    reset_n = 1'b1;
    tick();

    // First frame, then second streamed straight after
    send_frame(3, 1, 2, 4, 5);
    tick();
    chk_set("frame1", 3, 1, 2, 4, 5);
    chk("frame1_issue", issue, 1);
    chk("frame1_count", frame_count, 1);
    send_frame(7, 6, 5, 4, 3);
    tick();
    chk_set("frame2", 7, 6, 5, 4, 3);
    chk("frame2_issue", issue, 1);
    chk("frame2_count", frame_count, 2);
    chk("frame2_spacing", issue_cyc[issue_cyc.size()-1] - issue_cyc[issue_cyc.size()-2], 6);

    // Partial frame discarded by flush; same-cycle nibble dropped
    send_nib(9); send_nib(9);
    flush = 1'b1; in_valid = 1'b1; in_data = 4'd9;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    send_frame(1, 2, 3, 4, 5);
    wait_issue();
    chk_set("flush", 1, 2, 3, 4, 5);

    // Valid while not ready is ignored
    send_frame(10, 11, 12, 13, 14);
    in_valid = 1'b1; in_data = 4'd15;
    for (int n = 0; n < 50 && !in_ready; n++) tick();
    in_valid = 1'b0;
    wait_issue();
    chk_set("stall", 10, 11, 12, 13, 14);
    send_frame(1, 2, 3, 4, 6);
    wait_issue();
    chk_set("after_stall", 1, 2, 3, 4, 6);

    // Asynchronous reset between edges mid-hold
    tick(); tick();
    chk("pre_reset_busy", busy, 1);
    reset_n = 1'b0;
    #2;
    chk_set("async_reset", 0, 0, 0, 0, 0);
    chk("async_busy", busy, 0);
    chk("async_issue", issue, 0);
    chk("async_ready", in_ready, 1);
    chk("async_count", frame_count, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // Random traffic with occasional flush
    for (int n = 0; n < 3000; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = WIDTH'($urandom);
      flush    = ($urandom_range(0, 40) == 0);
      tick();
    end
    in_valid = 1'b0; flush = 1'b0;
    repeat (10) tick();

    // frame_count wrap
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    for (int f = 0; f < 256; f++)
      send_frame($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 15), $urandom_range(0, 15));
    repeat (10) tick();
    chk("wrap_count", frame_count, 0);
    send_frame(2, 4, 6, 8, 10);
    wait_issue();
    chk("wrap_count_next", frame_count, 1);
    chk_set("wrap_set", 2, 4, 6, 8, 10);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
